elevator_dispatch: RTL

- Upstream controller for elevator_car.
- Latches per-floor call requests and compares them with the car's current floor, which is the car's q, fed back.
- Drives the car's en/inc pair with a SCAN (elevator) policy.
- Sequences a timed door-open dwell at each serviced floor.

---
 rtl/elevator_dispatch.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/elevator_dispatch.sv
// elevator_dispatch: upstream SCAN controller for elevator_car.
// Latches floor calls, steers the car's en/inc pair and times the door dwell.
// Optional emergency stop input is compiled in with macro ELEVATOR_ESTOP_EN.
module elevator_dispatch #(
    parameter int NUM_FLOORS  = 8,
    parameter int DOOR_CYCLES = 4,
    parameter int TW          = 8
) (
    input  logic                  clk,
    input  logic                  init_n,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic [7:0]            cur_floor,
`ifdef ELEVATOR_ESTOP_EN
    input  logic                  estop,
`endif
    output logic                  en,
    output logic                  inc,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  fault
);

    typedef enum logic [1:0] {IDLE, UP, DOWN, DOOR} state_t;

    localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_CYCLES - 1);

    state_t                  state_reg, state_next;
    logic [NUM_FLOORS-1:0]   pending_reg, pending_next;
    logic [TW-1:0]           timer_reg, timer_next;
    logic                    dir_up_reg, dir_up_next;
    logic                    inc_reg;

    logic [31:0]             floor_ext;
    logic [NUM_FLOORS-1:0]   above_bits, below_bits, floor_hot, clear;
    logic                    above, below, here;

    assign floor_ext = {24'd0, cur_floor};

    // Per-floor comparison of latched calls against the car position.
    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            assign floor_hot[gi]  = (floor_ext == gi);
            assign above_bits[gi] = pending_reg[gi] && (gi > floor_ext);
            assign below_bits[gi] = pending_reg[gi] && (gi < floor_ext);
        end
    endgenerate

    assign above = |above_bits;
    assign below = |below_bits;
    assign here  = |(pending_reg & floor_hot);
    assign fault = (floor_ext >= NUM_FLOORS);

    // State, request latch, door timer and held direction registers.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            timer_reg   <= '0;
            dir_up_reg  <= 1'b1;
            inc_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            timer_reg   <= timer_next;
            dir_up_reg  <= dir_up_next;
            inc_reg     <= inc;
        end
    end

    // SCAN dispatch: next state, car drive, door control and request clearing.
    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        dir_up_next = dir_up_reg;
        en          = 1'b0;
        inc         = inc_reg;
        door_open   = 1'b0;
        clear       = '0;
        case (state_reg)
            IDLE: begin
                if (here) begin
                    state_next = DOOR;
                    clear      = floor_hot;
                    timer_next = '0;
                end else if (above && (dir_up_reg || !below)) begin
                    state_next  = UP;
                    dir_up_next = 1'b1;
                end else if (below) begin
                    state_next  = DOWN;
                    dir_up_next = 1'b0;
                end
            end
            UP: begin
                inc = 1'b1;
                if (here) begin
                    state_next = DOOR;
                    clear      = floor_hot;
                    timer_next = '0;
                end else if (!above) begin
                    state_next = IDLE;
                end else begin
                    en = (floor_ext != NUM_FLOORS - 1);
                end
            end
            DOWN: begin
                inc = 1'b0;
                if (here) begin
                    state_next = DOOR;
                    clear      = floor_hot;
                    timer_next = '0;
                end else if (!below) begin
                    state_next = IDLE;
                end else begin
                    en = (floor_ext != 0);
                end
            end
            DOOR: begin
                door_open = 1'b1;
                // A call for this floor while the door is open only extends the dwell.
                clear     = floor_hot;
                if (|(req & floor_hot)) begin
                    timer_next = '0;
                end else if (timer_reg == DOOR_LAST) begin
                    timer_next = '0;
                    if (dir_up_reg && above) begin
                        state_next = UP;
                    end else if (!dir_up_reg && below) begin
                        state_next = DOWN;
                    end else if (above) begin
                        state_next  = UP;
                        dir_up_next = 1'b1;
                    end else if (below) begin
                        state_next  = DOWN;
                        dir_up_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Car position outside the shaft: stop and wait, keeping calls.
        if (fault) begin
            en         = 1'b0;
            state_next = IDLE;
            timer_next = '0;
            clear      = '0;
        end
        pending_next = (pending_reg | req) & ~clear;
`ifdef ELEVATOR_ESTOP_EN
        // Emergency stop: car frozen, doors open, all calls dropped.
        if (estop) begin
            en           = 1'b0;
            door_open    = 1'b1;
            state_next   = IDLE;
            timer_next   = '0;
            pending_next = '0;
        end
`endif
    end

    assign pending = pending_reg;
    assign dir_up  = dir_up_reg;

endmodule
